// File: rtl/opcodes.sv
// rtl/opcodes.sv - shared CPU encodings, including the run-control sequencer states
package opcodes;

  typedef enum logic [1:0] {RC_HALT, RC_RUN, RC_STEP, RC_BRK} run_state_t;

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop button synchroniser with a one-cycle rising-edge pulse
module btn_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic Btn,
  output logic Pulse
);

  logic s1, s2, s3;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign Pulse = s2 & ~s3;

endmodule

// File: rtl/run_control.sv
// rtl/run_control.sv - run/halt/single-step/breakpoint sequencer driving the CPU execute enable
module run_control
  import opcodes::*;
#(
  parameter int n  = 8,
  parameter int CW = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          RunBtn,
  input  logic          StepBtn,
  input  logic          HaltBtn,
  input  logic          BrkEn,
  input  logic [n-1:0]  BrkAddr,
  input  logic [n-1:0]  Pc,
  output logic          CpuEn,
  output logic          Halted,
  output logic          AtBreak,
  output logic [CW-1:0] StepCount
);

  run_state_t state, state_n;
  logic       Skip, skip_n;
  logic       run_p, step_p, halt_p;
  logic       hit;

  btn_sync u_run  (.Clock(Clock), .Reset(Reset), .Btn(RunBtn),  .Pulse(run_p));
  btn_sync u_step (.Clock(Clock), .Reset(Reset), .Btn(StepBtn), .Pulse(step_p));
  btn_sync u_halt (.Clock(Clock), .Reset(Reset), .Btn(HaltBtn), .Pulse(halt_p));

  // Skip masks the breakpoint for the first RUN cycle so a resume executes BrkAddr once
  assign hit     = BrkEn & (Pc == BrkAddr) & ~Skip;
  assign CpuEn   = ((state == RC_RUN) & ~hit) | (state == RC_STEP);
  assign Halted  = (state == RC_HALT) | (state == RC_BRK);
  assign AtBreak = (state == RC_BRK);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RC_HALT;
      Skip  <= 1'b0;
    end else begin
      state <= state_n;
      Skip  <= skip_n;
    end
  end

  always_comb begin
    state_n = state;
    skip_n  = Skip;
    case (state)
      RC_HALT: begin
        if (run_p) begin
          state_n = RC_RUN;
          skip_n  = 1'b1;
        end else if (step_p) begin
          state_n = RC_STEP;
        end
      end
      RC_RUN: begin
        skip_n = 1'b0;
        if (hit)         state_n = RC_BRK;
        else if (halt_p) state_n = RC_HALT;
      end
      RC_STEP: state_n = RC_HALT;
      RC_BRK: begin
        if (run_p) begin
          state_n = RC_RUN;
          skip_n  = 1'b1;
        end else if (step_p) begin
          state_n = RC_STEP;
        end else if (halt_p) begin
          state_n = RC_HALT;
        end
      end
      default: state_n = RC_HALT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      StepCount <= '0;
    else if (CpuEn && (StepCount != {CW{1'b1}}))
      StepCount <= StepCount + CW'(1);
  end

endmodule

// File: doc/run_control.md
# run_control

Run/halt/single-step sequencer for the 8-bit accumulator CPU. It takes three debug push-buttons and a PC breakpoint, and drives `CpuEn`, the global execute enable the CPU ANDs into its PC advance and all architectural writes: PC, register file, accumulator and LED register. It sits beside the CPU at top level, between the board switches/buttons and the core, and exposes halt/break status plus an executed-cycle counter.

## Interface
- `n`, 8: PC/address width.
- `CW`, 16: width of `StepCount`.
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `RunBtn`  in  1  asynchronous button; rising edge requests RUN.
- `StepBtn`  in  1  asynchronous button; rising edge requests one executed cycle.
- `HaltBtn`  in  1  asynchronous button; rising edge requests HALT.
- `BrkEn`  in  1  breakpoint enable (synchronous level).
- `BrkAddr`  in  n  breakpoint PC.
- `Pc`  in  n  the CPU's current fetch address.
- `CpuEn`  out  1  CPU executes this cycle.
- `Halted`  out  1  state is HALT or BRK.
- `AtBreak`  out  1  state is BRK.
- `StepCount`  out  CW  number of cycles with `CpuEn`=1 since reset; saturating.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchroniser (`s1`, `s2`) plus a history flop `s3`. The pulse is `s2 & ~s3`, one cycle wide per rising edge. A held button gives exactly one pulse.
- **States.** HALT, RUN, STEP, BRK. There is also a `Skip` flag register.
- **Breakpoint hit.** `hit = BrkEn & (Pc == BrkAddr) & ~Skip`.
- **`CpuEn`** is combinational: (RUN & ~hit) | STEP.
- **HALT:**
  - run pulse → RUN, and `Skip` is set.
  - otherwise, step pulse → STEP.
  - halt pulse is ignored.
  - Run and step pulses in the same cycle → RUN (run has priority).
- **RUN:**
  - `hit` → BRK.
  - otherwise, halt pulse → HALT.
  - Run and step pulses are ignored.
  - `Skip` clears at the first edge in RUN.
- **STEP:** lasts exactly one cycle, then → HALT unconditionally. The breakpoint is ignored in STEP.
- **BRK:**
  - run pulse → RUN, with `Skip` set, so the instruction at `BrkAddr` executes once.
  - otherwise, step pulse → STEP.
  - halt pulse → HALT, and `AtBreak` clears.
- **Simultaneous hit and halt pulse in RUN** → BRK (break wins).
- **Status outputs:** `Halted` = HALT | BRK; `AtBreak` = BRK. Both are decoded from the state register.
- **`StepCount`:**
  - +1 on every edge where `CpuEn`=1.
  - Holds at all-ones (no wrap).
  - Unsigned, CW bits.
- **PC range.** `Pc` wrap (255→0) needs no special handling; the comparator is a plain n-bit equality.

## Timing
- **Reset** (asynchronous, takes effect without a clock edge):
  - state HALT, `Skip` 0, sync flops 0, `StepCount` 0.
  - Hence `CpuEn` 0, `Halted` 1, `AtBreak` 0.
- **Button latency.** Let E0 be the first edge sampling the button high.
  - The pulse is valid between E1 and E2.
  - The state changes at E2.
  - `CpuEn` is high after E2.
- **Step.** Exactly one cycle of `CpuEn`=1 per button press.
- **Halt.** The cycle in which the halt pulse is high still executes; `CpuEn` is 0 from the next edge.
- **Breakpoint.** `CpuEn` drops in the same cycle that `Pc` equals `BrkAddr`, so the instruction at `BrkAddr` does not execute on a hit; BRK is entered at the following edge.
- **Reset mid-RUN/STEP.** `CpuEn` falls asynchronously; partially conditioned button pulses are discarded.

## Structure
- `opcodes` package: add `typedef enum logic [1:0] {RC_HALT, RC_RUN, RC_STEP, RC_BRK} run_state_t`.
- Sub-module `btn_sync`: synchroniser plus rising-edge pulse, ports `Clock`, `Reset`, `Btn`, `Pulse`. Instantiated three times.
- Integration requirement on the CPU: `PcWait` is forced high, and `RegWe`/`AccStore`/`LedStore` are forced low, when `CpuEn`=0.

## Test plan
- **Reset:** assert `Reset` between edges → `CpuEn`=0, `Halted`=1, `AtBreak`=0, `StepCount`=0 immediately; all hold for 10 clocks with buttons idle.
- **Single step:** `StepBtn` held high 6 cycles from HALT → exactly one `CpuEn` cycle, starting after the 3rd edge; `StepCount`=1; back to HALT.
- **Breakpoint:** `BrkEn`=1, `BrkAddr`=8'h05, PC model starting at 0 and advancing only when `CpuEn`=1, press Run → `CpuEn` high for `Pc` 0..4, low at `Pc`=5; `AtBreak`=1; `StepCount`=5.
- **Resume from break:** from the previous end state, press Run → `Pc`=5 executes; PC wraps 255→0; stops at `Pc`=5 again; `StepCount`=261.
- **Simultaneous events and halt:** Run+Step pulsed in the same cycle from HALT → RUN. Halt pressed in RUN → `CpuEn` 0 one edge after the pulse. Halt pulse and hit in the same cycle → BRK.
- **Saturation and reset mid-RUN:** `CW`=4, free RUN, no breakpoint → `StepCount` stops at 15. Async `Reset` mid-RUN → `CpuEn` 0 with no clock edge; `StepCount`=0.
